// File: rtl/gpio_arb_pkg.sv
// Shared definitions for the two-master GPIO arbiter: register map, FSM states
// and the access legality rule.
package gpio_arb_pkg;

  localparam logic [31:0] GPIO_DDR_ADDR  = 32'd128;
  localparam logic [31:0] GPIO_PIN_ADDR  = 32'd129;
  localparam logic [31:0] GPIO_PORT_ADDR = 32'd130;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // PIN is read-only; the GPIO block clears DDR/PORT on any other write address.
  function automatic logic is_legal(input logic we, input logic [31:0] addr);
    if (we) return (addr == GPIO_DDR_ADDR) || (addr == GPIO_PORT_ADDR);
    return (addr >= GPIO_DDR_ADDR) && (addr <= GPIO_PORT_ADDR);
  endfunction

endpackage

// File: rtl/gpio_arb_rr.sv
// Combinational 2-way round-robin picker; a valid lock masks out the
// non-owner so only the lock owner can win.
module gpio_arb_rr
  import gpio_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lock_valid,
  input  logic       lock_owner,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] eligible;

  always_comb begin
    eligible = req;
    if (lock_valid) eligible = lock_owner ? (req & 2'b10) : (req & 2'b01);
    grant_valid = |eligible;
    grant_idx   = 1'b0;
    case (eligible)
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/gpio_arbiter.sv
// Shares the GPIO register port between two masters: one bus access per
// request, round-robin with optional lock, illegal accesses filtered out.
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic             m0_lock,
  output logic             m0_ack,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic             m1_lock,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m1_rdata,
  output logic             m1_err,
  output logic [WIDTH-1:0] g_addr,
  output logic [WIDTH-1:0] g_wdata,
  output logic             g_we,
  input  logic [WIDTH-1:0] g_rdata
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  state_t             state, state_nxt;
  logic               owner_q, we_q, lock_q, err_q;
  logic [WIDTH-1:0]   addr_q, wdata_q, rdata_q;
  logic               last_grant, lock_valid, lock_owner;
  logic [CNT_W-1:0]   to_cnt;
  logic               owner_req, lock_expire, grant_valid, grant_idx, legal;

  assign owner_req   = lock_owner ? m1_req : m0_req;
  // The release takes effect in the same IDLE cycle the count reaches the limit.
  assign lock_expire = lock_valid && (state == IDLE) && !owner_req &&
                       (to_cnt >= CNT_W'(LOCK_TIMEOUT - 1));
  assign legal       = is_legal(we_q, 32'(addr_q));

  gpio_arb_rr u_rr (
    .req        ({m1_req, m0_req}),
    .last_grant (last_grant),
    .lock_valid (lock_valid && !lock_expire),
    .lock_owner (lock_owner),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      lock_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      last_grant <= 1'b1;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      to_cnt     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_q    <= grant_idx;
            we_q       <= grant_idx ? m1_we    : m0_we;
            addr_q     <= grant_idx ? m1_addr  : m0_addr;
            wdata_q    <= grant_idx ? m1_wdata : m0_wdata;
            lock_q     <= grant_idx ? m1_lock  : m0_lock;
            last_grant <= grant_idx;
          end
          if (lock_expire) begin
            lock_valid <= 1'b0;
            to_cnt     <= '0;
          end else if (lock_valid) begin
            if (owner_req)                              to_cnt <= '0;
            else if (to_cnt != CNT_W'(LOCK_TIMEOUT))    to_cnt <= to_cnt + 1'b1;
          end
        end
        ACCESS: begin
          rdata_q <= (legal && !we_q) ? g_rdata : '0;
          err_q   <= !legal;
        end
        RESP: begin
          if (lock_q) begin
            lock_valid <= 1'b1;
            lock_owner <= owner_q;
            to_cnt     <= '0;
          end else if (lock_valid && (lock_owner == owner_q)) begin
            lock_valid <= 1'b0;
            to_cnt     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    g_addr    = '0;
    g_wdata   = '0;
    g_we      = 1'b0;
    m0_ack    = 1'b0;
    m1_ack    = 1'b0;
    m0_rdata  = '0;
    m1_rdata  = '0;
    m0_err    = 1'b0;
    m1_err    = 1'b0;
    case (state)
      IDLE:   if (grant_valid) state_nxt = ACCESS;
      ACCESS: begin
        g_addr    = addr_q;
        g_wdata   = wdata_q;
        g_we      = we_q && legal;
        state_nxt = RESP;
      end
      RESP: begin
        if (owner_q) begin
          m1_ack   = 1'b1;
          m1_rdata = rdata_q;
          m1_err   = err_q;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = rdata_q;
          m0_err   = err_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: a GPIO register model on the bus side, per-master
// drivers that push expected responses, and a monitor that pops them on ack.
module tb_gpio_arbiter;

  localparam logic [31:0] PIN_VAL = 32'h0000_003C;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  logic        clk, arst_n;
  logic        m0_req, m0_we, m0_lock, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_lock, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [31:0] g_addr, g_wdata, g_rdata;
  logic        g_we;

  logic [31:0] gpio_ddr, gpio_port;
  logic [31:0] exp_ddr, exp_port;
  exp_t        sb0[$];
  exp_t        sb1[$];
  int          tests, fails, cyc;
  logic        prev_gwe;

  gpio_arbiter #(.WIDTH(32), .LOCK_TIMEOUT(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .g_addr(g_addr), .g_wdata(g_wdata), .g_we(g_we), .g_rdata(g_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // GPIO register model: a write to any non-DDR/PORT address wipes both.
  always @(posedge clk) begin
    if (g_we) begin
      if (g_addr == 32'd128)      gpio_ddr  <= g_wdata;
      else if (g_addr == 32'd130) gpio_port <= g_wdata;
      else begin
        gpio_ddr  <= 32'h0;
        gpio_port <= 32'h0;
      end
    end
  end

  assign g_rdata = (g_addr == 32'd128) ? gpio_ddr :
                   (g_addr == 32'd129) ? PIN_VAL :
                   (g_addr == 32'd130) ? gpio_port : 32'hDEAD_BEEF;

  function automatic logic ref_legal(input logic we, input logic [31:0] addr);
    if (we) return (addr == 32'd128) || (addr == 32'd130);
    return (addr == 32'd128) || (addr == 32'd129) || (addr == 32'd130);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr);
    if (addr == 32'd128) return exp_ddr;
    if (addr == 32'd129) return PIN_VAL;
    return exp_port;
  endfunction

  // Response monitor: pops the scoreboard on every ack.
  initial begin
    exp_t e;
    prev_gwe = 1'b0;
    forever begin
      @(negedge clk);
      if (g_we) begin
        tests++;
        if (prev_gwe !== 1'b0) begin
          fails++;
          $display("FAIL g_we_consecutive: g_we high %0d cycles in a row, required 1", 2);
        end
      end
      prev_gwe = g_we;
      if (m0_ack) begin
        tests++;
        if (sb0.size() == 0) begin
          fails++;
          $display("FAIL m0_unexpected_ack: ack=1 at cycle %0d, required no ack", cyc);
        end else begin
          e = sb0.pop_front();
          if (m0_err !== e.err || (e.chk_rdata && m0_rdata !== e.rdata)) begin
            fails++;
            $display("FAIL m0_resp: err=%0b rdata=%h, required err=%0b rdata=%h",
                     m0_err, m0_rdata, e.err, e.rdata);
          end
        end
      end
      if (m1_ack) begin
        tests++;
        if (sb1.size() == 0) begin
          fails++;
          $display("FAIL m1_unexpected_ack: ack=1 at cycle %0d, required no ack", cyc);
        end else begin
          e = sb1.pop_front();
          if (m1_err !== e.err || (e.chk_rdata && m1_rdata !== e.rdata)) begin
            fails++;
            $display("FAIL m1_resp: err=%0b rdata=%h, required err=%0b rdata=%h",
                     m1_err, m1_rdata, e.err, e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction on master m; returns at the negedge where ack was seen
  // (req already dropped, which is harmless in RESP).
  task automatic txn(input int m, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic lock,
                     input int exp_lat, output int ack_cyc);
    exp_t e;
    int   start;
    logic got, gwe_prev, lg;
    lg          = ref_legal(we, addr);
    e.err       = !lg;
    e.chk_rdata = !we || !lg;
    e.rdata     = (!we && lg) ? ref_read(addr) : 32'h0;
    if (we && lg) begin
      if (addr == 32'd128) exp_ddr = wdata;
      else                 exp_port = wdata;
    end
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_lock = lock;
      sb0.push_back(e);
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_lock = lock;
      sb1.push_back(e);
    end
    start    = cyc;
    got      = 1'b0;
    gwe_prev = 1'b0;
    ack_cyc  = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) begin
        got     = 1'b1;
        ack_cyc = cyc;
      end else begin
        gwe_prev = g_we;
      end
    end
    if (m == 0) m0_req = 1'b0;
    else        m1_req = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL m%0d_ack_timeout: no ack in 40 cycles, required ack", m);
    end else begin
      tests++;
      if (gwe_prev !== (we && lg)) begin
        fails++;
        $display("FAIL m%0d_g_we addr=%0d: g_we=%0b in access, required %0b",
                 m, addr, gwe_prev, we && lg);
      end
      if (exp_lat >= 0) begin
        tests++;
        if (ack_cyc - start != exp_lat) begin
          fails++;
          $display("FAIL m%0d_latency: %0d cycles, required %0d", m, ack_cyc - start, exp_lat);
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_lock = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_lock = 1'b0;
    gpio_ddr = 32'h0; gpio_port = 32'h0; exp_ddr = 32'h0; exp_port = 32'h0;
    repeat (2) @(negedge clk);
    tests++;
    if ({m0_ack, m1_ack, m0_err, m1_err, g_we} !== 5'b0 ||
        m0_rdata !== 32'h0 || m1_rdata !== 32'h0 || g_addr !== 32'h0 || g_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b%b err=%b%b g_we=%b g_addr=%h, required all 0",
               m0_ack, m1_ack, m0_err, m1_err, g_we, g_addr);
    end
    arst_n = 1'b1;
  endtask

  task automatic test_read();
    int a;
    txn(0, 1'b1, 32'd130, 32'h0000_00A5, 1'b0, 2, a);
    txn(0, 1'b0, 32'd130, 32'h0, 1'b0, 2, a);
    txn(0, 1'b1, 32'd128, 32'h0000_000F, 1'b0, 2, a);
    txn(1, 1'b0, 32'd128, 32'h0, 1'b0, 2, a);
  endtask

  task automatic test_illegal();
    int a;
    txn(1, 1'b1, 32'd129, 32'h0000_0055, 1'b0, 2, a);
    txn(1, 1'b1, 32'd200, 32'h0000_0055, 1'b0, 2, a);
    txn(1, 1'b0, 32'd131, 32'h0, 1'b0, 2, a);
    txn(0, 1'b0, 32'd129, 32'h0, 1'b0, 2, a);
    tests++;
    if (gpio_ddr !== exp_ddr || gpio_port !== exp_port) begin
      fails++;
      $display("FAIL gpio_regs_after_illegal: ddr=%h port=%h, required ddr=%h port=%h",
               gpio_ddr, gpio_port, exp_ddr, exp_port);
    end
  endtask

  task automatic test_tie();
    int a1, a2, a3, a4, s;
    apply_reset();
    s = cyc + 1;
    fork
      begin
        txn(0, 1'b0, 32'd130, 32'h0, 1'b0, -1, a1);
        txn(0, 1'b0, 32'd128, 32'h0, 1'b0, -1, a3);
      end
      begin
        txn(1, 1'b0, 32'd129, 32'h0, 1'b0, -1, a2);
        txn(1, 1'b0, 32'd130, 32'h0, 1'b0, -1, a4);
      end
    join
    tests++;
    if (a1 != s + 2 || a2 != a1 + 3 || a3 != a2 + 3 || a4 != a3 + 3) begin
      fails++;
      $display("FAIL tie_order: acks m0=%0d m1=%0d m0=%0d m1=%0d, required %0d %0d %0d %0d",
               a1, a2, a3, a4, s + 2, s + 5, s + 8, s + 11);
    end
  endtask

  task automatic test_lock();
    int a1, a2, b1;
    fork
      begin
        txn(0, 1'b0, 32'd130, 32'h0, 1'b1, 2, a1);
        txn(0, 1'b1, 32'd130, 32'h0000_005A, 1'b0, 2, a2);
      end
      begin
        @(posedge clk);
        txn(1, 1'b0, 32'd128, 32'h0, 1'b0, -1, b1);
      end
    join
    tests++;
    if (a2 != a1 + 3 || b1 != a2 + 3) begin
      fails++;
      $display("FAIL lock_order: acks m0=%0d m0=%0d m1=%0d, required m1 at %0d after both m0",
               a1, a2, b1, a1 + 6);
    end
  endtask

  task automatic test_timeout();
    int a, b;
    txn(0, 1'b0, 32'd130, 32'h0, 1'b1, 2, a);
    txn(1, 1'b0, 32'd128, 32'h0, 1'b0, -1, b);
    tests++;
    if (b != a + 6) begin
      fails++;
      $display("FAIL lock_timeout: m1 ack at cycle %0d, required %0d", b, a + 6);
    end
    txn(1, 1'b0, 32'd130, 32'h0, 1'b0, 2, b);
  endtask

  task automatic test_reset_mid();
    int a;
    @(posedge clk);
    #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd128; m0_wdata = 32'h0000_00F0; m0_lock = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (g_we !== 1'b1 || g_addr !== 32'd128) begin
      fails++;
      $display("FAIL reset_mid_access: g_we=%0b g_addr=%0d, required 1 and 128", g_we, g_addr);
    end
    arst_n = 1'b0;
    #1;
    tests++;
    if (g_we !== 1'b0 || g_addr !== 32'h0 || m0_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_drop: g_we=%0b g_addr=%h ack=%0b, required all 0",
               g_we, g_addr, m0_ack);
    end
    m0_req = 1'b0;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    txn(0, 1'b0, 32'd128, 32'h0, 1'b0, 2, a);
    tests++;
    if (gpio_ddr !== exp_ddr) begin
      fails++;
      $display("FAIL reset_mid_ddr: ddr=%h, required %h", gpio_ddr, exp_ddr);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cyc   = 0;
    test_reset();
    test_read();
    test_illegal();
    test_lock();
    test_timeout();
    test_reset_mid();
    test_tie();
    repeat (4) @(negedge clk);
    tests++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d/%0d pending, required 0/0", sb0.size(), sb1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_arbiter.md
# gpio_arbiter

Two-master arbiter that shares the single memory-mapped GPIO register port (DDR at 128, PIN at 129, PORT at 130) between the CPU pipeline load/store stage (master 0) and a secondary bus master (master 1, e.g. debug/pattern engine). Each request becomes exactly one GPIO bus access. Arbitration is round-robin, with an optional lock for atomic read-modify-write sequences. Illegal accesses are filtered out and never reach the GPIO. The block sits between the masters and the GPIO register block; it drives that block's address, write-data and write-enable and samples its read data.

## Interface
Parameters:
- WIDTH, 32, data and address width (matches the GPIO register width)
- LOCK_TIMEOUT, 16, idle cycles after which an unused lock is forcibly released (≥1)

Ports (x = 0, 1 for the two master ports):
- clk  in  1  clock
- arst_n  in  1  reset; asynchronous, active-low
- mx_req  in  1  master x request; held until the master sees mx_ack
- mx_we  in  1  1 = write, 0 = read
- mx_addr  in  WIDTH  target address
- mx_wdata  in  WIDTH  write data
- mx_lock  in  1  keep the grant after this transaction
- mx_ack  out  1  one-cycle completion pulse
- mx_rdata  out  WIDTH  read data, valid while mx_ack = 1, else 0
- mx_err  out  1  illegal access, valid while mx_ack = 1
- g_addr  out  WIDTH  address to the GPIO block
- g_wdata  out  WIDTH  write data to the GPIO block
- g_we  out  1  write enable to the GPIO block
- g_rdata  in  WIDTH  combinational read data from the GPIO block

## Operation
- FSM states:
  - IDLE: pick a winner among the eligible requesters. If there is a winner, latch its we/addr/wdata/lock and go to ACCESS.
  - ACCESS: drive g_addr and g_wdata. Drive g_we = we AND legal. Capture g_rdata into the response register. Go to RESP.
  - RESP: pulse mx_ack, mx_rdata and mx_err for the owner. Go to IDLE.
- Legality:
  - A read is legal for addresses 128–130.
  - A write is legal for 128 and 130 only.
  - A write to 129 (PIN) or to any address outside 128–130 is illegal: g_we stays 0, err = 1, rdata = 0.
  - This rule is mandatory. The GPIO clears DDR and PORT on a write to any other address.
- Illegal read: err = 1, rdata = 0, g_addr is still driven (this is harmless).
- Round-robin:
  - last_grant register.
  - With both requests active and no lock, grant the master other than last_grant.
  - last_grant is updated on entry to ACCESS.
- Lock:
  - If the owner completes a transaction with lock = 1, lock_valid is set and lock_owner = owner.
  - While lock_valid, only lock_owner is eligible in IDLE.
  - The lock is cleared when the owner completes a transaction with lock = 0.
  - The lock is also cleared when lock_owner_req stays low in IDLE for LOCK_TIMEOUT consecutive cycles. The counter resets on any owner request.
- Idle bus: g_addr = 0, g_wdata = 0, g_we = 0 outside ACCESS.
- Reset values: state IDLE; all outputs 0; last_grant = 1 (so master 0 wins the first tie); lock_valid = 0; timeout counter 0.

## Timing
- Request sampled in IDLE at cycle N:
  - ACCESS (g_we pulse) in N+1.
  - mx_ack in N+2.
  - Next IDLE in N+3.
- Latency is 2 cycles from sampled request to ack. Throughput is one access per 3 cycles.
- The ack is registered. The master drops or changes req/addr the cycle after ack. A req still high in N+3 is a new transaction.
- g_we is high for exactly one cycle per legal write. It is never high for two consecutive cycles.
- Request inputs may change in ACCESS and RESP without effect; the values latched in IDLE are used.
- A request arriving at master y while x is in ACCESS or RESP waits. It is evaluated in the next IDLE.
- Timeout counter:
  - Saturates at LOCK_TIMEOUT.
  - The lock releases in the IDLE cycle where the count reaches LOCK_TIMEOUT. The other master can win in that same cycle.
- Reset asserted mid-transaction: all state and outputs go to reset values immediately (asynchronous). No ack is issued for the in-flight transaction. g_we drops at once.

## Structure
- Package gpio_arb_pkg holds:
  - GPIO_DDR_ADDR = 128, GPIO_PIN_ADDR = 129, GPIO_PORT_ADDR = 130.
  - State enum IDLE/ACCESS/RESP.
  - Function is_legal(we, addr).
- Sub-module gpio_arb_rr: combinational 2-way round-robin picker. Inputs req[1:0], last_grant, lock_valid, lock_owner. Outputs grant_valid and grant_idx.
- Top contains the FSM, latched request registers, response registers, lock state and timeout counter.

## Test plan
- Read: m0 reads 130 after a PORT write of 0xA5 → g_we never high, m0_ack at N+2 with m0_rdata = 0xA5, m0_err = 0.
- Illegal writes: m1 writes 0x55 to 129, then to 200 → g_we stays 0 both times, m1_err = 1, rdata = 0; DDR and PORT unchanged.
- Tie: m0 and m1 request simultaneously from reset, both holding req → grants alternate m0, m1, m0, m1; each ack is 3 cycles apart.
- Lock:
  - m0 issues lock = 1 read of 130, then a lock = 0 write of 130, while m1 requests continuously → both m0 transactions complete before m1's first ack.
  - With LOCK_TIMEOUT = 4, m0 locks then goes quiet → m1 is granted in the 4th IDLE cycle.
- Reset mid-transaction: arst_n pulsed low during ACCESS of a write to 128 → g_we falls immediately, no ack; after release the next m0 request completes normally with a 2-cycle latency.
